rand_req_arbiter: RTL

//   Shares one random source between NREQ requesters (dice, game, alarm-jitter logic in the watch).

---
 rtl/rand_req_arbiter.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/rand_req_arbiter.sv
// rand_req_arbiter: round-robin arbiter sharing one 16-bit Galois LFSR among NREQ requesters,
// range-mapped to [MIN,MAX] by bounded rejection. Optional seed reload ports: RAND_SEED_LOAD_EN.
module rand_req_arbiter #(
  parameter int          NREQ      = 4,
  parameter int          MIN       = 0,
  parameter int          MAX       = 5,
  parameter logic [15:0] SEED      = 16'hACE1,
  parameter int          MAX_RETRY = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NREQ-1:0]         req,
`ifdef RAND_SEED_LOAD_EN
  input  logic                    seed_load,
  input  logic [15:0]             seed,
`endif
  output logic [NREQ-1:0]         grant,
  output logic [NREQ-1:0]         done,
  output logic [31:0]             rnd_out,
  output logic [$clog2(NREQ)-1:0] rnd_id,
  output logic                    busy
);

  localparam int              IW      = $clog2(NREQ);
  localparam int              SPAN    = MAX - MIN;
  localparam int              RW      = $clog2(SPAN + 1);
  localparam int              TW      = (MAX_RETRY > 1) ? $clog2(MAX_RETRY) : 1;
  localparam logic [15:0]     TAPS    = 16'hB400;
  localparam logic [NREQ-1:0] ONE     = NREQ'(1);
  localparam logic [31:0]     SPAN32  = 32'(SPAN);
  localparam logic [31:0]     RANGE32 = 32'(SPAN + 1);
  localparam logic [31:0]     MIN32   = 32'(MIN);

  typedef enum logic [1:0] {S_IDLE, S_DRAW, S_DONE} state_e;

  state_e          state_q, state_d;
  logic [15:0]     lfsr_q, lfsr_d;
  logic [IW-1:0]   ptr_q, ptr_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic [TW-1:0]   retry_q, retry_d;
  logic [NREQ-1:0] grant_q, grant_d;
  logic [NREQ-1:0] done_q, done_d;
  logic [31:0]     rnd_out_q, rnd_out_d;
  logic [IW-1:0]   rnd_id_q, rnd_id_d;
  logic [IW-1:0]   pick;
  logic [31:0]     sample;
  logic            accept;
  logic            last_try;

  // First requesting index at or after ptr, wrapping modulo NREQ.
  always_comb begin
    logic [IW-1:0] pos;
    // NOTE: every combinational output gets a default before any branch so no latch is inferred.
    pick = ptr_q;
    pos  = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      pos = IW'((int'(ptr_q) + i) % NREQ);
      if (req[pos]) pick = pos;
    end
  end

  always_comb begin
    lfsr_d = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? TAPS : 16'h0000);
`ifdef RAND_SEED_LOAD_EN
    if (seed_load) lfsr_d = (seed == 16'h0000) ? SEED : seed;
`endif
  end

  assign sample   = 32'(lfsr_q[RW-1:0]);
  assign accept   = (sample <= SPAN32);
  assign last_try = (retry_q == TW'(MAX_RETRY - 1));

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    idx_d     = idx_q;
    retry_d   = retry_q;
    grant_d   = grant_q;
    done_d    = '0;
    rnd_out_d = rnd_out_q;
    rnd_id_d  = rnd_id_q;
    unique case (state_q)
      S_IDLE: begin
        if (|req) begin
          idx_d   = pick;
          grant_d = ONE << pick;
          retry_d = '0;
          state_d = S_DRAW;
        end
      end
      S_DRAW: begin
        // A withdrawn request aborts silently, leaving result and pointer untouched.
        if (!req[idx_q]) begin
          grant_d = '0;
          state_d = S_IDLE;
        end else if (accept || last_try) begin
          rnd_out_d = accept ? (sample + MIN32) : (sample - RANGE32 + MIN32);
          rnd_id_d  = idx_q;
          grant_d   = '0;
          done_d    = ONE << idx_q;
          state_d   = S_DONE;
        end else begin
          retry_d = retry_q + TW'(1);
        end
      end
      S_DONE: begin
        ptr_d   = (idx_q == IW'(NREQ - 1)) ? '0 : idx_q + IW'(1);
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      lfsr_q    <= SEED;
      ptr_q     <= '0;
      idx_q     <= '0;
      retry_q   <= '0;
      grant_q   <= '0;
      done_q    <= '0;
      rnd_out_q <= '0;
      rnd_id_q  <= '0;
    end else begin
      state_q   <= state_d;
      lfsr_q    <= lfsr_d;
      ptr_q     <= ptr_d;
      idx_q     <= idx_d;
      retry_q   <= retry_d;
      grant_q   <= grant_d;
      done_q    <= done_d;
      rnd_out_q <= rnd_out_d;
      rnd_id_q  <= rnd_id_d;
    end
  end

  assign grant   = grant_q;
  assign done    = done_q;
  assign rnd_out = rnd_out_q;
  assign rnd_id  = rnd_id_q;
  assign busy    = (state_q != S_IDLE);

endmodule
